// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, the CLRI
// extended opcode and the default vector table layout.
package interrupt_controller_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    SERVICE = 2'd2
  } intc_state_t;

  // Extended opcode the CPU decodes as CLRI (drives clear_interrupt)
  localparam logic [3:0] CLRI_EXT_CODE = 4'b1111;

  // Default handler table: source i lives at BASE + i*STRIDE
  localparam logic [15:0] DEF_VECTOR_BASE   = 16'h0010;
  localparam logic [15:0] DEF_VECTOR_STRIDE = 16'h0004;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for one asynchronous interrupt line followed by a
// rising-edge detector on the synchronized value.
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus one delay stage for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered, fixed-priority (lowest index wins), non-nesting interrupt
// controller. One source is offered to the CPU, acknowledged in fetch and
// retired by CLRI. Optional runtime mask register enabled by INTC_MASK_REG_EN;
// without it every source is permanently enabled.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned NUM_IRQ       = 8,
  parameter logic [15:0] VECTOR_BASE   = DEF_VECTOR_BASE,
  parameter logic [15:0] VECTOR_STRIDE = DEF_VECTOR_STRIDE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               request_interrupt,
  input  logic               clear_interrupt,
  input  logic               mask_wr_en,
  input  logic [NUM_IRQ-1:0] mask_wr_data,
  output logic               interrupt,
  output logic [15:0]        vector,
  output logic [3:0]         irq_id,
  output logic               in_service
);

  intc_state_t        state_q, state_d;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [3:0]         cur_id_q;
  logic [15:0]        vector_q;
  logic [3:0]         sel_id;
  logic [15:0]        sel_vector;
  logic               latch_id;
  logic               clr_cur;

  // One synchronizer/edge detector per interrupt line
  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (irq[g]),
      .rise  (rise[g])
    );
  end

`ifdef INTC_MASK_REG_EN
  logic [NUM_IRQ-1:0] mask_q;

  // Software-writable source enable mask, all sources enabled out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '1;
    end else if (mask_wr_en) begin
      mask_q <= mask_wr_data;
    end
  end

  assign mask = mask_q;
`else
  logic unused_mask_inputs;

  assign mask               = '1;
  assign unused_mask_inputs = mask_wr_en ^ (^mask_wr_data);
`endif

  // Masking only gates the IDLE selection; an offered source is never revoked
  assign active = pending_q & mask;

  // Lowest-index priority encoder over enabled pending sources
  always_comb begin
    sel_id = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (active[i]) begin
        sel_id = 4'(i);
      end
    end
  end

  // Handler address of the selected source, 16-bit wrap-around
  always_comb begin
    sel_vector = VECTOR_BASE + ({12'd0, sel_id} * VECTOR_STRIDE);
  end

  // Next-state logic; en=0 holds the FSM in place
  always_comb begin
    state_d  = state_q;
    latch_id = 1'b0;
    clr_cur  = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (|active) begin
            state_d  = OFFER;
            latch_id = 1'b1;
          end
        end
        OFFER: begin
          if (request_interrupt) begin
            state_d = SERVICE;
          end
        end
        SERVICE: begin
          if (clear_interrupt) begin
            state_d = IDLE;
            clr_cur = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pending update: a new edge on the retiring source wins over its clear
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      clr_vec[i] = clr_cur && (cur_id_q == 4'(i));
    end
    pending_d = (pending_q & ~clr_vec) | rise;
  end

  // FSM state and pending flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Selected source id and its vector, frozen from OFFER through SERVICE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_id_q <= '0;
      vector_q <= VECTOR_BASE;
    end else if (latch_id) begin
      cur_id_q <= sel_id;
      vector_q <= sel_vector;
    end
  end

  assign interrupt  = (state_q == OFFER);
  assign in_service = (state_q == SERVICE);
  assign irq_id     = cur_id_q;
  assign vector     = vector_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller (NUM_IRQ = 8).
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic [7:0]  irq = 8'h00;
  logic        request_interrupt = 1'b0;
  logic        clear_interrupt = 1'b0;
  logic        mask_wr_en = 1'b0;
  logic [7:0]  mask_wr_data = 8'h00;
  logic        interrupt;
  logic [15:0] vector;
  logic [3:0]  irq_id;
  logic        in_service;

  int n_checks = 0;
  int n_fail   = 0;

  interrupt_controller dut (
    .clk               (clk),
    .reset             (reset),
    .en                (en),
    .irq               (irq),
    .request_interrupt (request_interrupt),
    .clear_interrupt   (clear_interrupt),
    .mask_wr_en        (mask_wr_en),
    .mask_wr_data      (mask_wr_data),
    .interrupt         (interrupt),
    .vector            (vector),
    .irq_id            (irq_id),
    .in_service        (in_service)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold lines high for two clocks so the synchronizer captures them
  task automatic fire(input logic [7:0] lines);
    irq = lines;
    tick(2);
    irq = 8'h00;
  endtask

  task automatic wait_offer();
    for (int i = 0; i < 12; i++) begin
      if (interrupt === 1'b1) break;
      tick(1);
    end
  endtask

  task automatic ack();
    request_interrupt = 1'b1;
    tick(1);
    request_interrupt = 1'b0;
  endtask

  task automatic clri();
    clear_interrupt = 1'b1;
    tick(1);
    clear_interrupt = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_interrupt: got %b want 0", interrupt); end
    n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL reset_in_service: got %b want 0", in_service); end
    n_checks++; if (irq_id !== 4'd0) begin n_fail++; $display("FAIL reset_irq_id: got %0d want 0", irq_id); end
    n_checks++; if (vector !== 16'h0010) begin n_fail++; $display("FAIL reset_vector: got %h want 0010", vector); end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_single();
    irq = 8'h08;
    for (int c = 1; c <= 4; c++) begin
      tick(1);
      if (c == 2) irq = 8'h00;
      if (c < 4) begin
        n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL single_early_c%0d: got %b want 0", c, interrupt); end
      end
    end
    n_checks++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL single_latency: got %b want 1", interrupt); end
    n_checks++; if (irq_id !== 4'd3) begin n_fail++; $display("FAIL single_id: got %0d want 3", irq_id); end
    n_checks++; if (vector !== 16'h001C) begin n_fail++; $display("FAIL single_vector: got %h want 001c", vector); end
    ack();
    n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL single_ack_int: got %b want 0", interrupt); end
    n_checks++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL single_ack_svc: got %b want 1", in_service); end
    n_checks++; if (irq_id !== 4'd3) begin n_fail++; $display("FAIL single_svc_id: got %0d want 3", irq_id); end
    clri();
    tick(4);
    n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL single_clear_svc: got %b want 0", in_service); end
    n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL single_no_reoffer: got %b want 0", interrupt); end
  endtask

  task automatic test_priority();
    fire(8'h22);
    wait_offer();
    n_checks++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL prio_offer_timeout: got %b want 1", interrupt); end
    n_checks++; if (irq_id !== 4'd1) begin n_fail++; $display("FAIL prio_first_id: got %0d want 1", irq_id); end
    n_checks++; if (vector !== 16'h0014) begin n_fail++; $display("FAIL prio_first_vec: got %h want 0014", vector); end
    ack();
    clri();
    n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL prio_idle_gap: got %b want 0", interrupt); end
    tick(1);
    n_checks++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL prio_second_offer: got %b want 1", interrupt); end
    n_checks++; if (irq_id !== 4'd5) begin n_fail++; $display("FAIL prio_second_id: got %0d want 5", irq_id); end
    n_checks++; if (vector !== 16'h0024) begin n_fail++; $display("FAIL prio_second_vec: got %h want 0024", vector); end
    ack();
    clri();
    tick(2);
  endtask

  task automatic test_no_nesting();
    fire(8'h10);
    wait_offer();
    n_checks++; if (irq_id !== 4'd4) begin n_fail++; $display("FAIL nest_first_id: got %0d want 4", irq_id); end
    ack();
    fire(8'h01);
    tick(6);
    n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL nest_no_offer: got %b want 0", interrupt); end
    n_checks++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL nest_still_svc: got %b want 1", in_service); end
    n_checks++; if (irq_id !== 4'd4) begin n_fail++; $display("FAIL nest_id_held: got %0d want 4", irq_id); end
    n_checks++; if (vector !== 16'h0020) begin n_fail++; $display("FAIL nest_vec_held: got %h want 0020", vector); end
    clri();
    tick(1);
    n_checks++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL nest_after_offer: got %b want 1", interrupt); end
    n_checks++; if (irq_id !== 4'd0) begin n_fail++; $display("FAIL nest_after_id: got %0d want 0", irq_id); end
    n_checks++; if (vector !== 16'h0010) begin n_fail++; $display("FAIL nest_after_vec: got %h want 0010", vector); end
    ack();
    clri();
    tick(2);
  endtask

  task automatic test_ignored();
    clri();
    n_checks++; if (interrupt !== 1'b0 || in_service !== 1'b0) begin n_fail++; $display("FAIL ign_clr_idle: got int=%b svc=%b want 0 0", interrupt, in_service); end
    fire(8'h40);
    wait_offer();
    n_checks++; if (irq_id !== 4'd6) begin n_fail++; $display("FAIL ign_offer_id: got %0d want 6", irq_id); end
    clri();
    n_checks++; if (interrupt !== 1'b1 || in_service !== 1'b0) begin n_fail++; $display("FAIL ign_clr_offer: got int=%b svc=%b want 1 0", interrupt, in_service); end
    en = 1'b0;
    request_interrupt = 1'b1;
    tick(2);
    n_checks++; if (interrupt !== 1'b1 || in_service !== 1'b0) begin n_fail++; $display("FAIL ign_ack_en0: got int=%b svc=%b want 1 0", interrupt, in_service); end
    en = 1'b1;
    tick(1);
    request_interrupt = 1'b0;
    n_checks++; if (interrupt !== 1'b0 || in_service !== 1'b1) begin n_fail++; $display("FAIL ign_ack_en1: got int=%b svc=%b want 0 1", interrupt, in_service); end
    en = 1'b0;
    clear_interrupt = 1'b1;
    tick(2);
    n_checks++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL ign_clr_en0: got %b want 1", in_service); end
    en = 1'b1;
    tick(1);
    clear_interrupt = 1'b0;
    n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL ign_clr_en1: got %b want 0", in_service); end
    tick(2);
  endtask

  task automatic test_set_wins();
    fire(8'h04);
    wait_offer();
    n_checks++; if (irq_id !== 4'd2) begin n_fail++; $display("FAIL setwin_first_id: got %0d want 2", irq_id); end
    ack();
    // Edge reaches pending on the same clock that retires source 2
    irq = 8'h04;
    tick(2);
    irq = 8'h00;
    clri();
    n_checks++; if (interrupt !== 1'b0 || in_service !== 1'b0) begin n_fail++; $display("FAIL setwin_idle: got int=%b svc=%b want 0 0", interrupt, in_service); end
    tick(1);
    n_checks++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL setwin_reoffer: got %b want 1", interrupt); end
    n_checks++; if (irq_id !== 4'd2) begin n_fail++; $display("FAIL setwin_id: got %0d want 2", irq_id); end
    ack();
    clri();
    tick(4);
    n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL setwin_drained: got %b want 0", interrupt); end
  endtask

  task automatic test_reset_mid_service();
    ack();
    n_checks++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL rst_pre_svc: got %b want 1", in_service); end
    reset = 1'b1;
    #2;
    n_checks++; if (interrupt !== 1'b0 || in_service !== 1'b0) begin n_fail++; $display("FAIL rst_async_state: got int=%b svc=%b want 0 0", interrupt, in_service); end
    n_checks++; if (irq_id !== 4'd0) begin n_fail++; $display("FAIL rst_async_id: got %0d want 0", irq_id); end
    n_checks++; if (vector !== 16'h0010) begin n_fail++; $display("FAIL rst_async_vec: got %h want 0010", vector); end
    tick(1);
    reset = 1'b0;
    tick(6);
    n_checks++; if (interrupt !== 1'b0 || in_service !== 1'b0) begin n_fail++; $display("FAIL rst_source_lost: got int=%b svc=%b want 0 0", interrupt, in_service); end
  endtask

`ifdef INTC_MASK_REG_EN
  task automatic test_mask();
    mask_wr_en = 1'b1;
    mask_wr_data = 8'hFE;
    tick(1);
    mask_wr_en = 1'b0;
    fire(8'h01);
    tick(6);
    n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL mask_blocked: got %b want 0", interrupt); end
    mask_wr_en = 1'b1;
    mask_wr_data = 8'hFF;
    tick(1);
    mask_wr_en = 1'b0;
    tick(1);
    n_checks++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL mask_unblocked: got %b want 1", interrupt); end
    n_checks++; if (irq_id !== 4'd0) begin n_fail++; $display("FAIL mask_id: got %0d want 0", irq_id); end
    n_checks++; if (vector !== 16'h0010) begin n_fail++; $display("FAIL mask_vec: got %h want 0010", vector); end
    test_reset_mid_service();
  endtask
`else
  task automatic test_mask_ignored();
    mask_wr_en = 1'b1;
    mask_wr_data = 8'h00;
    tick(1);
    mask_wr_en = 1'b0;
    fire(8'h80);
    wait_offer();
    n_checks++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL nomask_offer: got %b want 1", interrupt); end
    n_checks++; if (irq_id !== 4'd7) begin n_fail++; $display("FAIL nomask_id: got %0d want 7", irq_id); end
    n_checks++; if (vector !== 16'h002C) begin n_fail++; $display("FAIL nomask_vec: got %h want 002c", vector); end
    test_reset_mid_service();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_no_nesting();
    test_ignored();
    test_set_wins();
`ifdef INTC_MASK_REG_EN
    test_mask();
`else
    test_mask_ignored();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
